// File: rtl/xilinx_jtag_host_shifter.sv
// ---------------------------------------------------------------------------
// xilinx_jtag_host_shifter
//
// PL-side JTAG initiator for the x_heep_system debug TAP. Each accepted
// command shifts cmd_len_i TCK pulses. TMS/TDI are taken LSB first from
// the command vectors. TDO is sampled on every rising TCK, and the captured
// vector is returned through a valid/ready response channel.
//
// Ports
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   cmd_valid_i/ready_o   command handshake (ready only while idle)
//   cmd_len_i             number of TCK pulses (1..MAX_LEN legal)
//   cmd_tms_i/tdi_i       per-pulse TMS/TDI bits, bit i used on pulse i
//   rsp_valid_o/ready_i   response handshake, response held until taken
//   rsp_tdo_o             captured TDO, bit i sampled on pulse i
//   rsp_err_o             command length was 0 or above MAX_LEN
//   trst_req_i            level request for TAP reset
//   busy_o                high whenever the shifter is not idle
//   jtag_*                pins towards the target TAP (TRST active-low)
// ---------------------------------------------------------------------------
module xilinx_jtag_host_shifter #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len_i,
    input  logic [MAX_LEN-1:0]           cmd_tms_i,
    input  logic [MAX_LEN-1:0]           cmd_tdi_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [MAX_LEN-1:0]           rsp_tdo_o,
    output logic                         rsp_err_o,
    input  logic                         trst_req_i,
    output logic                         busy_o,
    output logic                         jtag_tck_o,
    output logic                         jtag_tms_o,
    output logic                         jtag_tdi_o,
    input  logic                         jtag_tdo_i,
    output logic                         jtag_trst_no
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int BIT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] tms_vec_q, tms_vec_d;
    logic [MAX_LEN-1:0] tdi_vec_q, tdi_vec_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               trst_n_q, trst_n_d;

    logic               div_last;
    logic               bit_last;
    logic               len_ok;
    logic [BIT_W-1:0]   bit_next;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last = ((32'(bit_q) + 32'd1) == 32'(len_q));
    assign len_ok   = (cmd_len_i != '0) && (32'(cmd_len_i) <= 32'(MAX_LEN));
    assign bit_next = bit_q + BIT_W'(1);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        len_d       = len_q;
        tms_vec_d   = tms_vec_q;
        tdi_vec_d   = tdi_vec_q;
        cap_d       = cap_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        // TRST is a plain registered copy of the request, independent of
        // the shift engine.
        trst_n_d    = ~trst_req_i;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    cap_d     = '0;
                    rsp_err_d = 1'b0;
                    if (len_ok) begin
                        // First TMS/TDI bit is presented immediately, so it
                        // gets a full low phase of setup before rising TCK.
                        state_d   = ST_LOW;
                        len_d     = cmd_len_i;
                        tms_vec_d = cmd_tms_i;
                        tdi_vec_d = cmd_tdi_i;
                        bit_d     = '0;
                        div_d     = '0;
                        tck_d     = 1'b0;
                        tms_d     = cmd_tms_i[0];
                        tdi_d     = cmd_tdi_i[0];
                    end else begin
                        // Illegal length: answer at once, pins untouched.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end

            ST_LOW: begin
                if (div_last) begin
                    div_d        = '0;
                    tck_d        = 1'b1;
                    cap_d[bit_q] = jtag_tdo_i;
                    state_d      = ST_HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_HIGH: begin
                if (div_last) begin
                    div_d = '0;
                    tck_d = 1'b0;
                    if (bit_last) begin
                        // TMS/TDI keep their last value after the final pulse.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        bit_d   = bit_next;
                        tms_d   = tms_vec_q[bit_next];
                        tdi_d   = tdi_vec_q[bit_next];
                        state_d = ST_LOW;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            len_q       <= '0;
            tms_vec_q   <= '0;
            tdi_vec_q   <= '0;
            cap_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            trst_n_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            len_q       <= len_d;
            tms_vec_q   <= tms_vec_d;
            tdi_vec_q   <= tdi_vec_d;
            cap_q       <= cap_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            trst_n_q    <= trst_n_d;
        end
    end

    // Ready is gated by reset so it stays low while rst_i is held.
    assign cmd_ready_o  = (state_q == ST_IDLE) && !rst_i;
    assign busy_o       = (state_q != ST_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_tdo_o    = cap_q;
    assign rsp_err_o    = rsp_err_q;
    assign jtag_tck_o   = tck_q;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = trst_n_q;

endmodule

// File: doc/xilinx_jtag_host_shifter.md
Name: xilinx_jtag_host_shifter

Overview:
- PL-side JTAG initiator. Turns buffered command words into TCK/TMS/TDI bit sequences and captures TDO.
- Drives the x_heep_system debug TAP. It is the host end of the JTAG link, so PS software can issue shift commands through a register/FIFO front-end instead of bit-banging GPIO.
- Sits between the PS command interface and the x_heep_system jtag_* pins in the FPGA wrapper.

Parameters:
- CLK_DIV, 4, TCK half-period in clk_i cycles; legal range is 1 or more.
- MAX_LEN, 32, maximum bits per command; also the width of the TMS/TDI/TDO vectors.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_len_i  in  $clog2(MAX_LEN+1)  number of TCK pulses
- cmd_tms_i  in  MAX_LEN  TMS per pulse, LSB first
- cmd_tdi_i  in  MAX_LEN  TDI per pulse, LSB first
- rsp_valid_o  out  1  response valid, held until accepted
- rsp_ready_i  in  1  response consumer ready
- rsp_tdo_o  out  MAX_LEN  captured TDO; bit i = sample of pulse i
- rsp_err_o  out  1  command length was illegal
- trst_req_i  in  1  level request to assert TAP reset
- busy_o  out  1  state != IDLE
- jtag_tck_o  out  1  TCK
- jtag_tms_o  out  1  TMS
- jtag_tdi_o  out  1  TDI
- jtag_tdo_i  in  1  TDO from target
- jtag_trst_no  out  1  TRST, active-low

Behaviour:
- Reset values (while rst_i is high):
  - tck=0, tms=1, tdi=0, trst_no=0
  - rsp_valid=0, rsp_tdo=0, rsp_err=0, busy=0
  - cmd_ready=0 during reset, 1 in IDLE after release
- rst_i asserted mid-operation: all state and outputs return to reset values immediately; any in-flight command and pending response are discarded.
- jtag_trst_no: registered ~trst_req_i, one cycle latency. Independent of the FSM; shifting continues during TRST.
- FSM states: IDLE, LOW, HIGH, RESP.
- cmd_ready_o is asserted only in IDLE.
- IDLE -> LOW on accept at cycle T:
  - Load shift registers; clear capture register; bit counter = 0.
  - At T+1: tms_o = tms[0], tdi_o = tdi[0], tck_o = 0.
- IDLE -> RESP on accept with cmd_len 0 or cmd_len > MAX_LEN:
  - No TCK pulse; pin outputs unchanged.
  - rsp_valid at T+1 with rsp_err=1 and rsp_tdo=0.
- LOW: hold for CLK_DIV cycles, then go to HIGH.
  - On the transition edge, set tck_o=1 and sample jtag_tdo_i into capture bit[counter].
- HIGH: hold for CLK_DIV cycles, then on the transition edge set tck_o=0:
  - If counter == len-1: go to RESP. tms/tdi hold their last value; rsp_valid=1, rsp_err=0.
  - Else: counter+1; present next tms/tdi bits on the same edge; go to LOW.
- Timing: TMS/TDI change only with the TCK falling edge, so each gets CLK_DIV cycles of setup before rising TCK.
  - First rising TCK at T+1+CLK_DIV.
  - rsp_valid at T+1+2·CLK_DIV·len.
- rsp_tdo bits at index len and above are 0.
- RESP: hold rsp_valid, rsp_tdo and rsp_err stable until rsp_ready_i.
  - On the handshake cycle: rsp_valid clears; next state IDLE, so cmd_ready=1 the following cycle.
  - There is no same-cycle response/command overlap.
- cmd_* inputs are ignored unless accepted. Changes to cmd_* after accept have no effect.
- Counters: the divide counter counts 0..CLK_DIV-1 with wrap. Bit counter width is $clog2(MAX_LEN).

Test Plan:
1. Reset, then release rst_i. Required: tck=0, tms=1, trst_no=0 during reset; trst_no=1 one cycle after release; cmd_ready=1.
2. CLK_DIV=4, len=5, tms=5'b11111, tdi=0, TDO tied 1. Required: exactly 5 TCK pulses of 4 high / 4 low cycles; rsp_valid at T+41; rsp_tdo=32'h1F; rsp_err=0.
3. len=32, tdi=32'hA5C3_0F96, TDO looped back from tdi_o. Required: rsp_tdo=32'hA5C3_0F96. TMS/TDI are checked stable across each rising edge; toggles occur only on falling edges.
4. len=0, then len=33. Required: each gives rsp_valid at T+1, rsp_err=1, rsp_tdo=0, no TCK activity. Hold rsp_ready=0 for 10 cycles: response stays stable and cmd_ready stays 0.
5. Assert rst_i at the 3rd TCK high phase of a len=8 command. Required: tck→0 and tms→1 asynchronously; no rsp_valid; after release, a new command completes normally.
6. Pulse trst_req_i during a len=8 shift. Required: trst_no low for the same duration, delayed by one cycle; shift completes with the correct rsp_tdo.
